// File: rtl/bs_pkg.sv
// bs_pkg: shared constants and state encoding for the bitstream packer.
//   DATA_WD / CODE_WD / LEN_WD / NUM_WD : default widths of the packer ports
//   TLR_WD                              : width of the adler32 trailer
//   state_t                             : packer control states
package bs_pkg;

    localparam int DATA_WD = 32;
    localparam int CODE_WD = 16;
    localparam int LEN_WD  = 5;
    localparam int NUM_WD  = 2;
    localparam int TLR_WD  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAD,
        S_TLR,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/bs_acc.sv
// bs_acc: 2*DATA_WD-bit bit accumulator for the packer.
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   clr_i         : drop all buffered bits (highest priority)
//   shift_i       : remove the low DATA_WD bits (a word was taken)
//   pad_i         : round the fill count up to a byte boundary
//   app_en_i      : append app_dat_i (app_len_i bits) above the current fill
//   app_dat_i     : data to append, LSB first
//   app_len_i     : number of bits to append, 0..DATA_WD
//   word_o        : low DATA_WD bits of the accumulator
//   cnt_o         : fill count, 0..2*DATA_WD
// Bits above the fill count are always zero, so padding only moves the count
// and a partial final word needs no extra masking.
module bs_acc #(
    parameter int DATA_WD = 32,
    parameter int CNT_WD  = 7
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic               pad_i,
    input  logic               app_en_i,
    input  logic [DATA_WD-1:0] app_dat_i,
    input  logic [CNT_WD-1:0]  app_len_i,
    output logic [DATA_WD-1:0] word_o,
    output logic [CNT_WD-1:0]  cnt_o
);
    import bs_pkg::*;

    localparam int ACC_WD = 2 * DATA_WD;
    localparam logic [CNT_WD-1:0] DW_CNT = CNT_WD'(DATA_WD);
    localparam logic [ACC_WD-1:0] LOW_ONES = {{DATA_WD{1'b0}}, {DATA_WD{1'b1}}};

    logic [ACC_WD-1:0] acc_q, acc_d;
    logic [CNT_WD-1:0] cnt_q, cnt_d;
    logic [CNT_WD-1:0] cnt_pad;
    logic [CNT_WD-1:0] mask_sh;
    logic [ACC_WD-1:0] app_mask;
    logic [ACC_WD-1:0] app_val;

    // Shift first, then pad, then append: a code taken in the same cycle as
    // a word leaves lands directly after the remaining bits.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        cnt_pad  = '0;
        mask_sh  = DW_CNT - app_len_i;
        app_mask = LOW_ONES >> mask_sh;
        app_val  = {{DATA_WD{1'b0}}, app_dat_i} & app_mask;
        if (shift_i) begin
            acc_d = acc_q >> DATA_WD;
            cnt_d = cnt_q - DW_CNT;
        end
        if (pad_i) begin
            cnt_pad = cnt_d + CNT_WD'(7);
            cnt_d   = {cnt_pad[CNT_WD-1:3], 3'b000};
        end
        if (app_en_i) begin
            acc_d = acc_d | (app_val << cnt_d);
            cnt_d = cnt_d + app_len_i;
        end
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign word_o = acc_q[DATA_WD-1:0];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/bs_pack_gen.sv
// bs_pack_gen: packs LSB-first Huffman codes into DATA_WD-bit words, pads the
// stream to a byte boundary, appends a big-endian adler32 trailer and flushes
// a final partial word tagged with a byte count.
// Ports:
//   clk, rstn                  : clock, synchronous active-low reset
//   start_i                    : begin a new stream (aborts any current one)
//   val_i/rdy_o                : code handshake
//   cod_dat_i/cod_len_i/lst_i  : code bits, code length, last code of stream
//   tlr_val_i/tlr_dat_i        : adler32 trailer, taken in TLR when room exists
//   val_o/rdy_i                : output word handshake
//   dat_o/num_o/lst_o          : packed word, valid bytes minus 1, last word
//   done_o                     : one-cycle pulse once the last word has left
// Optional macro BS_CRC_NUM_EN adds crc32_val_o/crc32_num_o/crc32_lst_o, which
// mark exactly the bytes that were handshaken downstream.
module bs_pack_gen #(
    parameter int DATA_WD = bs_pkg::DATA_WD,
    parameter int CODE_WD = bs_pkg::CODE_WD,
    parameter int LEN_WD  = bs_pkg::LEN_WD,
    parameter int NUM_WD  = bs_pkg::NUM_WD
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic               val_i,
    output logic               rdy_o,
    input  logic [CODE_WD-1:0] cod_dat_i,
    input  logic [LEN_WD-1:0]  cod_len_i,
    input  logic               lst_i,
    input  logic               tlr_val_i,
    input  logic [31:0]        tlr_dat_i,
    output logic               val_o,
    input  logic               rdy_i,
    output logic [DATA_WD-1:0] dat_o,
    output logic [NUM_WD-1:0]  num_o,
    output logic               lst_o,
    output logic               done_o
`ifdef BS_CRC_NUM_EN
    ,
    output logic               crc32_val_o,
    output logic [NUM_WD-1:0]  crc32_num_o,
    output logic               crc32_lst_o
`endif
);
    import bs_pkg::*;

    localparam int CNT_WD = $clog2(2 * DATA_WD + 1);
    localparam logic [CNT_WD-1:0] DW_CNT  = CNT_WD'(DATA_WD);
    localparam logic [CNT_WD-1:0] TLR_CNT = CNT_WD'(TLR_WD);

    state_t state_q, state_d;
    logic               val_q, val_d;
    logic [DATA_WD-1:0] dat_q, dat_d;
    logic [NUM_WD-1:0]  num_q, num_d;
    logic               lst_q, lst_d;
    logic               done_q, done_d;

    logic [DATA_WD-1:0] acc_word;
    logic [CNT_WD-1:0]  cnt;
    logic               accept, tlr_take, out_free, fin_ok;
    logic               load_full, load_fin;
    logic [TLR_WD-1:0]  tlr_swap;
    logic [DATA_WD-1:0] app_dat;
    logic [CNT_WD-1:0]  app_len;
    logic [CNT_WD-1:0]  fin_bytes;

    // Handshake qualifiers; start_i outranks every other request.
    assign rdy_o     = (state_q == S_RUN) && (cnt < DW_CNT);
    assign accept    = rdy_o && val_i && !start_i;
    assign tlr_take  = (state_q == S_TLR) && (cnt < DW_CNT) && tlr_val_i && !start_i;
    assign out_free  = !val_q || rdy_i;
    assign fin_ok    = (state_q == S_DRAIN) && (cnt != '0) && (cnt <= DW_CNT);
    assign load_full = out_free && (cnt >= DW_CNT) && !fin_ok && !start_i;
    assign load_fin  = out_free && fin_ok && !start_i;

    // The trailer is big-endian in the byte stream, so its top byte must sit
    // lowest in the LSB-first accumulator.
    assign tlr_swap  = {tlr_dat_i[7:0], tlr_dat_i[15:8], tlr_dat_i[23:16], tlr_dat_i[31:24]};
    assign app_dat   = tlr_take ? DATA_WD'(tlr_swap) : DATA_WD'(cod_dat_i);
    assign app_len   = tlr_take ? TLR_CNT : CNT_WD'(cod_len_i);
    assign fin_bytes = (cnt >> 3) - CNT_WD'(1);

    bs_acc #(
        .DATA_WD (DATA_WD),
        .CNT_WD  (CNT_WD)
    ) u_acc (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (start_i || load_fin),
        .shift_i   (load_full),
        .pad_i     ((state_q == S_PAD) && !start_i),
        .app_en_i  (accept || tlr_take),
        .app_dat_i (app_dat),
        .app_len_i (app_len),
        .word_o    (acc_word),
        .cnt_o     (cnt)
    );

    // Next-state decode for the stream control sequence.
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_RUN:   if (accept && lst_i) state_d = S_PAD;
                S_PAD:   state_d = S_TLR;
                S_TLR:   if (tlr_take) state_d = S_DRAIN;
                S_DRAIN: if (val_q && lst_q && rdy_i) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output register: a handshake empties it, a full or final word refills
    // it, and it holds otherwise so downstream sees a stable word.
    always_comb begin
        val_d  = val_q;
        dat_d  = dat_q;
        num_d  = num_q;
        lst_d  = lst_q;
        done_d = (state_q == S_DRAIN) && (state_d == S_DONE);
        if (val_q && rdy_i) begin
            val_d = 1'b0;
            lst_d = 1'b0;
        end
        if (load_full) begin
            val_d = 1'b1;
            dat_d = acc_word;
            num_d = '1;
            lst_d = 1'b0;
        end
        if (load_fin) begin
            val_d = 1'b1;
            dat_d = acc_word;
            num_d = NUM_WD'(fin_bytes);
            lst_d = 1'b1;
        end
        if (start_i) begin
            val_d  = 1'b0;
            lst_d  = 1'b0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            val_q   <= 1'b0;
            dat_q   <= '0;
            num_q   <= '0;
            lst_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            dat_q   <= dat_d;
            num_q   <= num_d;
            lst_q   <= lst_d;
            done_q  <= done_d;
        end
    end

    assign val_o  = val_q;
    assign dat_o  = dat_q;
    assign num_o  = num_q;
    assign lst_o  = lst_q;
    assign done_o = done_q;

`ifdef BS_CRC_NUM_EN
    assign crc32_val_o = val_q && rdy_i;
    assign crc32_num_o = num_q;
    assign crc32_lst_o = lst_q && val_q && rdy_i;
`endif

endmodule

// File: tb/tb_bs_pack_gen.sv
// tb_bs_pack_gen: directed and random stimulus for bs_pack_gen (default
// widths). A bit-queue model of the byte stream predicts every output word.
module tb_bs_pack_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic        val_i;
    logic        rdy_o;
    logic [15:0] cod_dat_i;
    logic [4:0]  cod_len_i;
    logic        lst_i;
    logic        tlr_val_i;
    logic [31:0] tlr_dat_i;
    logic        val_o;
    logic        rdy_i;
    logic [31:0] dat_o;
    logic [1:0]  num_o;
    logic        lst_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    // Stream model: bits not yet handshaken downstream, in stream order.
    bit   mbits[$];
    bit   tlr_done = 0;
    bit   expect_tlr = 0;
    logic [31:0] seen_dat[$];
    logic [1:0]  seen_num[$];
    logic        seen_lst[$];

    bit rdy_mode  = 0;
    bit rdy_fixed = 1;

    bs_pack_gen dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .val_i     (val_i),
        .rdy_o     (rdy_o),
        .cod_dat_i (cod_dat_i),
        .cod_len_i (cod_len_i),
        .lst_i     (lst_i),
        .tlr_val_i (tlr_val_i),
        .tlr_dat_i (tlr_dat_i),
        .val_o     (val_o),
        .rdy_i     (rdy_i),
        .dat_o     (dat_o),
        .num_o     (num_o),
        .lst_o     (lst_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream ready: fixed level or a coin flip every cycle.
    initial begin
        rdy_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rdy_i = rdy_mode ? 1'($urandom_range(1)) : rdy_fixed;
        end
    end

    // Monitor and reference model, sampled on the falling edge so every
    // input and output is stable for the coming rising edge.
    logic        prev_val = 0, prev_rdy = 0, prev_lst = 0, prev_start = 0, prev_done = 0;
    logic        prev_rstn = 0;
    logic [31:0] prev_dat = 0;
    logic [1:0]  prev_num = 0;

    always @(negedge clk) begin
        bit          fin;
        int          n;
        logic [63:0] exp_dat;
        if (!rstn) begin
            mbits.delete();
            tlr_done   = 0;
            expect_tlr = 0;
        end else begin
            if (val_o && rdy_i) begin
                fin = tlr_done && (mbits.size() <= 32);
                checkOutput("word_has_bits", 64'(fin || mbits.size() >= 32), 64'd1);
                n = fin ? mbits.size() : 32;
                if (n > mbits.size()) n = mbits.size();
                exp_dat = '0;
                for (int i = 0; i < n; i++) exp_dat[i] = mbits.pop_front();
                checkOutput("word_dat", 64'(dat_o), exp_dat);
                checkOutput("word_num", 64'(num_o), fin ? 64'((n / 8 - 1) & 3) : 64'd3);
                checkOutput("word_lst", 64'(lst_o), 64'(fin));
                seen_dat.push_back(dat_o);
                seen_num.push_back(num_o);
                seen_lst.push_back(lst_o);
                if (fin) tlr_done = 0;
            end
            if (prev_rstn && prev_val && !prev_rdy && !prev_start) begin
                checkOutput("hold_stable", {29'd0, val_o, lst_o, num_o, dat_o},
                            {29'd0, 1'b1, prev_lst, prev_num, prev_dat});
            end
            if (done_o) begin
                checkOutput("done_single", 64'(prev_done), 64'd0);
                checkOutput("done_drained", 64'(mbits.size()), 64'd0);
                done_cnt++;
            end
            if (start_i) begin
                mbits.delete();
                tlr_done   = 0;
                expect_tlr = 0;
            end else begin
                if (val_i && rdy_o) begin
                    for (int i = 0; i < cod_len_i; i++) mbits.push_back(cod_dat_i[i]);
                    if (lst_i) begin
                        while ((mbits.size() % 8) != 0) mbits.push_back(1'b0);
                        expect_tlr = 1;
                    end
                end
                if (tlr_val_i && expect_tlr) begin
                    for (int b = 3; b >= 0; b--)
                        for (int i = 0; i < 8; i++) mbits.push_back(tlr_dat_i[b*8+i]);
                    expect_tlr = 0;
                    tlr_done   = 1;
                end
            end
        end
        prev_rstn  = rstn;
        prev_val   = val_o;
        prev_rdy   = rdy_i;
        prev_lst   = lst_o;
        prev_start = start_i;
        prev_done  = done_o;
        prev_dat   = dat_o;
        prev_num   = num_o;
    end

    // Present one code and hold it until the packer takes it.
    task automatic applyStimulus(input logic [15:0] d, input logic [4:0] l, input logic last);
        bit got = 0;
        val_i     = 1'b1;
        cod_dat_i = d;
        cod_len_i = l;
        lst_i     = last;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy_o) begin
                got = 1;
                break;
            end
        end
        checkOutput("accept_in_time", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        val_i = 1'b0;
        lst_i = 1'b0;
    endtask

    task automatic pulseStart();
        @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Drain with ready high so the trailer is guaranteed room, then offer it.
    task automatic sendTrailer(input logic [31:0] t, input bit rnd_after);
        rdy_mode  = 0;
        rdy_fixed = 1;
        repeat (6) @(posedge clk);
        #1;
        tlr_val_i = 1'b1;
        tlr_dat_i = t;
        @(posedge clk);
        #1;
        tlr_val_i = 1'b0;
        rdy_mode  = rnd_after;
    endtask

    task automatic waitDone();
        int  target = done_cnt + 1;
        bit  got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                got = 1;
                break;
            end
        end
        checkOutput("done_in_time", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitWords(input int target);
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (seen_dat.size() >= target) begin
                got = 1;
                break;
            end
        end
        checkOutput("words_in_time", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] c;
        rstn = 1'b0; start_i = 1'b0; val_i = 1'b0; cod_dat_i = '0; cod_len_i = '0;
        lst_i = 1'b0; tlr_val_i = 1'b0; tlr_dat_i = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {25'd0, val_o, rdy_o, lst_o, done_o, num_o, dat_o}, 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checkOutput("idle_rdy", 64'(rdy_o), 64'd0);
        pulseStart();
        @(negedge clk);
        checkOutput("run_rdy", 64'(rdy_o), 64'd1);
        @(posedge clk);
        #1;

        // Four byte codes make one full word
        seen_dat.delete(); seen_num.delete(); seen_lst.delete();
        applyStimulus(16'h11, 5'd8, 1'b0);
        applyStimulus(16'h22, 5'd8, 1'b0);
        applyStimulus(16'h33, 5'd8, 1'b0);
        applyStimulus(16'h44, 5'd8, 1'b0);
        waitWords(1);
        checkOutput("bytes_word", 64'(seen_dat[0]), 64'h44332211);
        checkOutput("bytes_num", 64'(seen_num[0]), 64'd3);

        // Two 12-bit codes plus trailer
        pulseStart();
        seen_dat.delete(); seen_num.delete(); seen_lst.delete();
        applyStimulus(16'h0ABC, 5'd12, 1'b0);
        applyStimulus(16'hF123, 5'd12, 1'b1);
        sendTrailer(32'h01020304, 0);
        waitDone();
        checkOutput("t3_count", 64'(seen_dat.size()), 64'd2);
        checkOutput("t3_w0", 64'(seen_dat[0]), 64'h01123ABC);
        checkOutput("t3_n0", 64'(seen_num[0]), 64'd3);
        checkOutput("t3_w1", 64'(seen_dat[1]), 64'h00040302);
        checkOutput("t3_n1", 64'(seen_num[1]), 64'd2);
        checkOutput("t3_l1", 64'(seen_lst[1]), 64'd1);

        // Byte-align padding before the trailer
        pulseStart();
        seen_dat.delete(); seen_num.delete(); seen_lst.delete();
        applyStimulus(16'hFFFD, 5'd3, 1'b1);
        sendTrailer(32'hDEADBEEF, 0);
        waitDone();
        checkOutput("t4_w0", 64'(seen_dat[0]), 64'hBEADDE05);
        checkOutput("t4_n0", 64'(seen_num[0]), 64'd3);
        checkOutput("t4_w1", 64'(seen_dat[1]), 64'h000000EF);
        checkOutput("t4_n1", 64'(seen_num[1]), 64'd0);
        checkOutput("t4_l1", 64'(seen_lst[1]), 64'd1);

        // Backpressure for 20 cycles under continuous 16-bit codes
        pulseStart();
        seen_dat.delete(); seen_num.delete(); seen_lst.delete();
        rdy_fixed = 0;
        for (int i = 1; i <= 4; i++) applyStimulus(16'hA000 + 16'(i), 5'd16, 1'b0);
        val_i = 1'b1; cod_dat_i = 16'hA005; cod_len_i = 5'd16; lst_i = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("bp_rdy_low", 64'(rdy_o), 64'd0);
        checkOutput("bp_val_held", 64'(val_o), 64'd1);
        checkOutput("bp_dat_held", 64'(dat_o), 64'hA002A001);
        rdy_fixed = 1;
        applyStimulus(16'hA005, 5'd16, 1'b0);
        for (int i = 6; i <= 9; i++) applyStimulus(16'hA000 + 16'(i), 5'd16, i == 9);
        sendTrailer(32'h0BADF00D, 0);
        waitDone();
        checkOutput("bp_first", 64'(seen_dat[0]), 64'hA002A001);

        // Abort with 40 bits buffered, then zero-length codes
        pulseStart();
        rdy_fixed = 0;
        applyStimulus(16'h1111, 5'd16, 1'b0);
        applyStimulus(16'h2222, 5'd16, 1'b0);
        applyStimulus(16'h0033, 5'd8, 1'b0);
        applyStimulus(16'h4444, 5'd16, 1'b0);
        applyStimulus(16'h5555, 5'd16, 1'b0);
        pulseStart();
        @(negedge clk);
        checkOutput("abort_val", 64'(val_o), 64'd0);
        checkOutput("abort_rdy", 64'(rdy_o), 64'd1);
        @(posedge clk);
        #1;
        rdy_fixed = 1;
        seen_dat.delete(); seen_num.delete(); seen_lst.delete();
        applyStimulus(16'hFFFF, 5'd0, 1'b0);
        applyStimulus(16'hFF77, 5'd8, 1'b0);
        applyStimulus(16'hFFFF, 5'd0, 1'b0);
        applyStimulus(16'h0088, 5'd8, 1'b0);
        applyStimulus(16'h0099, 5'd8, 1'b0);
        applyStimulus(16'h00AA, 5'd8, 1'b1);
        sendTrailer(32'h01020304, 0);
        waitDone();
        checkOutput("abort_w0", 64'(seen_dat[0]), 64'hAA998877);
        checkOutput("abort_w1", 64'(seen_dat[1]), 64'h04030201);
        checkOutput("abort_n1", 64'(seen_num[1]), 64'd3);
        checkOutput("abort_l1", 64'(seen_lst[1]), 64'd1);

        // Random streams with random downstream ready
        for (int s = 0; s < 4; s++) begin
            pulseStart();
            rdy_mode = 1;
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                c = 16'($urandom);
                applyStimulus(c, 5'($urandom_range(16)), k == 39);
            end
            sendTrailer($urandom, 1);
            waitDone();
        end
        rdy_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
